param_sync_fifo: RTL

Parametrised single-clock FIFO and next-generation buffer for the design's inter-stage queues. Adds configurable width, depth and read mode (registered or first-word-fall-through) over the existing fixed FIFO. Also adds occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow flags with explicit clear. Keeps the existing wr_tog/rd_tog pointer-wrap outputs and the combined error output.

---
 rtl/param_sync_fifo.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: parametrised single-clock FIFO with registered or first-word-fall-through read.
//
// Ports:
//   clk          clock; all state updates on the rising edge
//   rst          asynchronous active-low reset
//   wr_en/wdata  write request and data; accepted when not full
//   rd_en        read/pop request; accepted when not empty
//   flush        synchronous flush of pointers, wrap bits and count
//   err_clr      clears the sticky overflow/underflow flags
//   rdata        read data (registered, or head word when FWFT=1)
//   full, empty, almost_full, almost_empty, count   occupancy status
//   wr_tog/rd_tog                                   pointer wrap bits
//   overflow/underflow/error                        sticky error flags

module param_sync_fifo #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned PTR_WIDTH = 6,
    parameter int unsigned FWFT      = 0,
    parameter int unsigned AF_THRESH = 56,
    parameter int unsigned AE_THRESH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 rd_en,
    input  logic                 flush,
    input  logic                 err_clr,
    output logic [WIDTH-1:0]     rdata,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [PTR_WIDTH:0]   count,
    output logic                 wr_tog,
    output logic                 rd_tog,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 error
);

    // Elaboration-time parameter sanity checks.
    if (PTR_WIDTH != $clog2(DEPTH)) begin : g_bad_ptr_width
        $error("PTR_WIDTH must equal log2(DEPTH)");
    end
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 4");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH) || (AE_THRESH >= DEPTH)) begin : g_bad_thresh
        $error("almost-full/almost-empty thresholds out of range");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("WIDTH must be at least 1");
    end

    localparam logic [PTR_WIDTH:0]   DepthCnt = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH:0]   AfCnt    = (PTR_WIDTH + 1)'(AF_THRESH);
    localparam logic [PTR_WIDTH:0]   AeCnt    = (PTR_WIDTH + 1)'(AE_THRESH);
    localparam logic [PTR_WIDTH:0]   CntOne   = {{PTR_WIDTH{1'b0}}, 1'b1};
    localparam logic [PTR_WIDTH-1:0] PtrOne   = {{(PTR_WIDTH - 1){1'b0}}, 1'b1};
    localparam logic [PTR_WIDTH-1:0] PtrMax   = {PTR_WIDTH{1'b1}};

    logic [WIDTH-1:0]     mem [DEPTH];

    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic                 wr_tog_q, wr_tog_d;
    logic                 rd_tog_q, rd_tog_d;
    logic [PTR_WIDTH:0]   count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic                 wr_acc, rd_acc;
    logic                 ptr_eq;

    // full/empty come from the {tog,ptr} pairs; count is kept alongside for status outputs.
    assign ptr_eq = (wr_ptr_q == rd_ptr_q);
    assign empty  = ptr_eq & (wr_tog_q == rd_tog_q);
    assign full   = ptr_eq & (wr_tog_q != rd_tog_q);

    // Flush suppresses both acceptance and error detection for that cycle.
    assign wr_acc = wr_en & ~full & ~flush;
    assign rd_acc = rd_en & ~empty & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wr_tog_d = wr_tog_q;
        rd_tog_d = rd_tog_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            wr_tog_d = 1'b0;
            rd_tog_d = 1'b0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
                if (wr_ptr_q == PtrMax) begin
                    wr_tog_d = ~wr_tog_q;
                end
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
                if (rd_ptr_q == PtrMax) begin
                    rd_tog_d = ~rd_tog_q;
                end
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CntOne;
                2'b01:   count_d = count_q - CntOne;
                default: count_d = count_q;
            endcase
        end
    end

    // A new error event in the same cycle wins over err_clr.
    always_comb begin
        overflow_d  = (overflow_q & ~err_clr) | (wr_en & full & ~flush);
        underflow_d = (underflow_q & ~err_clr) | (rd_en & empty & ~flush);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wr_tog_q    <= 1'b0;
            rd_tog_q    <= 1'b0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_tog_q    <= wr_tog_d;
            rd_tog_q    <= rd_tog_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; stale words are unreachable once pointers are cleared.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    if (FWFT == 0) begin : g_reg_read
        logic [WIDTH-1:0] rdata_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rdata_q <= '0;
            end else if (rd_acc) begin
                rdata_q <= mem[rd_ptr_q];
            end
        end

        assign rdata = rdata_q;
    end else begin : g_fwft_read
        // Head word is exposed directly; drive zero while empty so reset shows a clean value.
        assign rdata = empty ? '0 : mem[rd_ptr_q];
    end

    assign count        = count_q;
    assign almost_full  = (count_q >= AfCnt);
    assign almost_empty = (count_q <= AeCnt);
    assign wr_tog       = wr_tog_q;
    assign rd_tog       = rd_tog_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign error        = overflow_q | underflow_q;

    a_flags_match_count: assert property (@(posedge clk) disable iff (!rst)
        (full == (count_q == DepthCnt)) && (empty == (count_q == '0)));

endmodule
